// File: rtl/fp_pkg.sv
// Shared constants and types for the signed fixed-point operator family.
package fp_pkg;

  localparam int unsigned FpWidth  = 32;
  localparam int unsigned FracBits = FpWidth / 2;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } fp_state_e;

endpackage

// File: rtl/fp_sqrt_step.sv
// One restoring digit-by-digit square-root step: consumes two radicand bits, yields one root bit.
module fp_sqrt_step #(
  parameter int unsigned RootW = 24,
  parameter int unsigned RemW  = RootW + 2
) (
  input  logic [RemW-1:0]  rem_i,
  input  logic [RootW-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [RemW-1:0]  rem_o,
  output logic [RootW-1:0] root_o
);

  logic [RemW-1:0] shifted;
  logic [RemW-1:0] trial;
  logic            ge;

  // The remainder never exceeds 2*root, so the bits shifted out at the top are always zero.
  assign shifted = {rem_i[RemW-3:0], bits_i};
  assign trial   = RemW'({root_i, 2'b01});
  assign ge      = (shifted >= trial);

  assign rem_o  = ge ? (shifted - trial) : shifted;
  assign root_o = {root_i[RootW-2:0], ge};

endmodule

// File: rtl/fp_sqrt.sv
// Iterative fixed-point square root with valid/ready handshakes on both sides.
module fp_sqrt
  import fp_pkg::*;
#(
  parameter int unsigned n = FpWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] result,
  output logic         neg
);

  localparam int unsigned Iter = 3 * n / 4;
  localparam int unsigned RadW = n + n / 2;
  localparam int unsigned RemW = Iter + 2;
  localparam int unsigned CntW = $clog2(Iter + 1);

  fp_state_e         state_q, state_d;
  logic [RadW-1:0]   rad_q, rad_d;
  logic [RemW-1:0]   rem_q, rem_d;
  logic [Iter-1:0]   root_q, root_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]      result_q, result_d;
  logic              neg_q, neg_d;

  logic [RemW-1:0]   step_rem;
  logic [Iter-1:0]   step_root;

  fp_sqrt_step #(
    .RootW (Iter),
    .RemW  (RemW)
  ) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[RadW-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (a[n-1]) begin
            result_d = '0;
            neg_d    = 1'b1;
            state_d  = StDone;
          end else begin
            rad_d   = {a, {(n / 2){1'b0}}};
            rem_d   = '0;
            root_d  = '0;
            neg_d   = 1'b0;
            cnt_d   = CntW'(Iter);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d             = '0;
          result_d[Iter-1:0]   = step_root;
          state_d              = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_fp_sqrt.sv
// Self-checking bench for fp_sqrt (n=32): directed table, randomized model check, handshake corners.
module tb_fp_sqrt;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        neg;

  int checks;
  int failures;

  fp_sqrt #(.n(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp_result;
    logic        exp_neg;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: floor(sqrt(a * 2^16)) by binary search over the integer square.
  function automatic logic [31:0] model_sqrt(input logic [31:0] av);
    longint unsigned x;
    longint unsigned lo;
    longint unsigned hi;
    longint unsigned mid;
    if (av[31]) return 32'h0;
    x  = longint'(av) * 65536;
    lo = 0;
    hi = 64'd1 << 24;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  // Accept one radicand and wait for out_valid; noisy drives in_valid/out_ready/a garbage during CALC.
  task automatic run_op(input logic [31:0] av, input bit noisy,
                        output logic [31:0] res, output logic ng, output int lat);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a        = av;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = noisy;
    lat      = 0;
    while (lat < 100) begin
      if (noisy) begin
        a         = $urandom;
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) chk("timeout_out_valid", 64'(out_valid), 64'd1);
    res = result;
    ng  = neg;
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] res;
    logic        ng;
    int          lat;
    logic [31:0] held;
    logic [31:0] rv;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;

    vecs[0] = '{32'h0004_0000, 32'h0002_0000, 1'b0, 24};
    vecs[1] = '{32'h0002_0000, 32'h0001_6A09, 1'b0, 24};
    vecs[2] = '{32'h0000_0001, 32'h0000_0100, 1'b0, 24};
    vecs[3] = '{32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, 24};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 24};
    vecs[5] = '{32'hFFFF_0000, 32'h0000_0000, 1'b1, 1};
    vecs[6] = '{32'h0009_0000, 32'h0003_0000, 1'b0, 24};

    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_neg", 64'(neg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, 1'b0, res, ng, lat);
      chk($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_result));
      chk($sformatf("vec%0d_neg", i), 64'(ng), 64'(vecs[i].exp_neg));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      release_op();
    end

    for (int i = 0; i < 40; i++) begin
      unique case (i % 4)
        0:       rv = $urandom;
        1:       rv = $urandom & 32'h7FFF_FFFF;
        2:       rv = $urandom_range(0, 255);
        default: rv = {1'b0, 15'($urandom), 16'h0};
      endcase
      run_op(rv, 1'b0, res, ng, lat);
      chk($sformatf("rand%0d_result a=%0h", i, rv), 64'(res), 64'(model_sqrt(rv)));
      chk($sformatf("rand%0d_neg", i), 64'(ng), 64'(rv[31]));
      chk($sformatf("rand%0d_latency", i), 64'(lat), rv[31] ? 64'd1 : 64'd24);
      release_op();
    end

    // Garbage in_valid/out_ready during CALC must not disturb the computation.
    run_op(32'h0002_0000, 1'b1, res, ng, lat);
    chk("noisy_result", 64'(res), 64'h0001_6A09);
    chk("noisy_latency", 64'(lat), 64'd24);

    // Hold DONE with back-pressure while new radicands are offered.
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = $urandom;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_result", i), 64'(result), 64'(held));
      chk($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op();
    run_op(32'h0004_0000, 1'b0, res, ng, lat);
    chk("after_hold_result", 64'(res), 64'h0002_0000);
    release_op();

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    a        = 32'h0004_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_pulse", 64'(out_valid), 64'd0);
    end
    run_op(32'h0009_0000, 1'b0, res, ng, lat);
    chk("post_rst_result", 64'(res), 64'h0003_0000);
    chk("post_rst_neg", 64'(ng), 64'd0);
    chk("post_rst_latency", 64'(lat), 64'd24);
    release_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_sqrt.md
FP_SQRT -- requirements
Module: fp_sqrt

Interface
REQ-001 Parameter: n, default 32, total word width of the signed fixed-point format, with n/2 integer bits (incl. sign) and n/2 fraction bits; n SHALL be even and at least 8.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  radicand on a is valid.
REQ-005 Port: in_ready  output  1  block can accept a radicand.
REQ-006 Port: a  input  n  signed two's-complement radicand.
REQ-007 Port: out_valid  output  1  result and neg are valid.
REQ-008 Port: out_ready  input  1  consumer accepts the result.
REQ-009 Port: result  output  n  square root, same fixed-point format as a.
REQ-010 Port: neg  output  1  radicand was negative; result is forced to 0.

Function
REQ-011 States SHALL be IDLE, CALC and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded from registered state.
REQ-012 An accept edge is a rising edge with in_valid && in_ready; the block SHALL capture a only on an accept edge.
REQ-013 On accept with a[n-1]==1, the block SHALL go to DONE with result=0 and neg=1, so out_valid is high after exactly 1 edge.
REQ-014 On accept with a[n-1]==0, the block SHALL go to CALC, load the radicand R = a << (n/2) (3n/2 bits, zero-extended), clear the root and remainder, set neg=0, and set the iteration counter to ITER = 3n/4.
REQ-015 CALC SHALL perform one restoring digit-by-digit step per edge, one root bit per step, MSB first: remainder = (remainder<<2)|next 2 radicand bits; trial = (root<<2)|1; if remainder >= trial then subtract and shift in root bit 1, else shift in 0.
REQ-016 After the ITER-th CALC edge, the block SHALL go to DONE; out_valid is high exactly ITER edges after the accept edge (24 for n=32).
REQ-017 result SHALL equal floor(sqrt(a * 2^(n/2))) taken as an integer, i.e. truncated (not rounded) toward zero; the root always fits in n-1 bits, so no overflow handling is needed.
REQ-018 a==0 SHALL take the normal CALC path and produce result=0 with neg=0.
REQ-019 In DONE, result and neg SHALL hold stable until an edge with out_ready==1, at which the block returns to IDLE; there is no bypass from DONE to CALC (in_ready stays low in DONE).
REQ-020 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT disturb an operation in progress.
REQ-021 out_ready while not in DONE SHALL have no effect.
REQ-022 result SHALL remain unchanged outside the DONE-load and CALC updates; intermediate CALC values are not required to be visible on result.

Reset
REQ-023 While rst_n==0, state SHALL be IDLE, result=0, neg=0, remainder/root/counter=0, in_ready=1 and out_valid=0, independent of clk.
REQ-024 Reset asserted in CALC or DONE SHALL abort the operation with no output pulse; the first accept after release SHALL start a fresh computation.

Structure
REQ-025 Package fp_pkg SHALL hold the default width constant, the fraction-bit count (n/2) and the state enum type (IDLE, CALC, DONE), shared with the other fixed-point operators.
REQ-026 The combinational step of REQ-015 SHALL be a sub-module fp_sqrt_step (inputs: remainder, root, 2 radicand bits; outputs: next remainder, next root), so it can be unrolled later for a pipelined variant.
REQ-027 The top level SHALL contain only the FSM, the counter, the shift registers and the output registers; target is 120-400 lines in total.

Verification (n=32)
REQ-028 a=0x00040000 (4.0) -> out_valid 24 edges after accept, result=0x00020000, neg=0.
REQ-029 a=0x00020000 (2.0) -> result=0x00016A09 (truncated sqrt 2); a=0x00000001 -> result=0x00000100.
REQ-030 a=0x7FFFFFFF -> result=0x00B504F3; a=0x00000000 -> result=0x00000000, neg=0, latency 24.
REQ-031 a=0xFFFF0000 (-1.0) -> out_valid after 1 edge, result=0, neg=1.
REQ-032 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a changing -> result stays stable and in_ready stays 0; out_ready=1 -> IDLE next edge, then a new accept is taken.
REQ-033 Drive rst_n low at CALC iteration 10, asynchronously mid-cycle -> immediate IDLE, out_valid=0, result=0; after release, a=0x00090000 -> result=0x00030000.
